// File: rtl/vfu_out_serializer_if.sv
// vfu_out_serializer_if
//   Bundles the VFU result strobe with the downstream lane stream.
//   vect_in_flat : N*16-bit result vector, lane i at bits [i*16 +: 16]
//   in_tvalid    : one-cycle strobe from the VFU, no backpressure
//   m_tdata      : current 16-bit FP16 lane
//   m_tvalid     : m_tdata valid
//   m_tready     : downstream accepts the beat
//   m_tlast      : marks lane N-1 of each vector
// The master modport is the serializer; the slave modport is the
// VFU plus downstream side that drives it.
interface vfu_out_serializer_if #(
  parameter int N = 4
);
  logic [N*16-1:0] vect_in_flat;
  logic            in_tvalid;
  logic [15:0]     m_tdata;
  logic            m_tvalid;
  logic            m_tready;
  logic            m_tlast;

  modport master (
    input  vect_in_flat, in_tvalid, m_tready,
    output m_tdata, m_tvalid, m_tlast
  );

  modport slave (
    output vect_in_flat, in_tvalid, m_tready,
    input  m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/vfu_out_serializer.sv
// vfu_out_serializer
//   Captures whole N-lane FP16 vectors strobed by the VFU into a
//   DEPTH-entry FIFO and replays them one lane per beat, lane 0 first,
//   on a ready/valid stream with last-beat marking.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   bus      : vfu_out_serializer_if.master (vector in, lane stream out)
//   level    : vectors stored, including the one being replayed
//   overflow : sticky, a vector was dropped because the FIFO was full
module vfu_out_serializer #(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  vfu_out_serializer_if.master      bus,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(N - 1);
  localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state;
  logic [N*16-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   rd_next;
  logic [LW-1:0]   lane;
  logic [LW-1:0]   lane_next;
  logic [AW:0]     level_after_pop;
  logic [AW:0]     level_next;
  logic            beat;
  logic            pop;
  logic            push;
  logic            full;
  logic [N*16-1:0] head_next;

  // Next-state view of the FIFO. A push while full is still accepted when
  // the head vector finishes on the same edge, since that frees its slot.
  // The outputs are registered from the post-edge state, so when the FIFO
  // drains to empty on the same edge a new vector arrives, the new head is
  // taken straight from the input (its slot is only written on this edge).
  always_comb begin
    full            = (level == FULL_LEVEL);
    beat            = bus.m_tvalid && bus.m_tready;
    pop             = beat && (lane == LAST_LANE);
    push            = bus.in_tvalid && (!full || pop);
    level_after_pop = pop ? level - (AW + 1)'(1) : level;
    level_next      = push ? level_after_pop + (AW + 1)'(1) : level_after_pop;
    rd_next         = pop ? rd_ptr + AW'(1) : rd_ptr;
    lane_next       = lane;
    if (pop) begin
      lane_next = '0;
    end else if (beat) begin
      lane_next = lane + LW'(1);
    end
    head_next = mem[rd_next];
    if (push && (level_after_pop == '0)) begin
      head_next = bus.vect_in_flat;
    end
  end

  // Vector storage carries no reset; only the pointers and level qualify it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.vect_in_flat;
    end
  end

  // Pointers, level, overflow and the replay FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      lane         <= '0;
      level        <= '0;
      overflow     <= 1'b0;
      bus.m_tvalid <= 1'b0;
      bus.m_tdata  <= '0;
      bus.m_tlast  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (bus.in_tvalid && !push) begin
        overflow <= 1'b1;
      end
      rd_ptr <= rd_next;
      lane   <= lane_next;
      level  <= level_next;
      case (state)
        IDLE, SEND: begin
          if (level_next != '0) begin
            state        <= SEND;
            bus.m_tvalid <= 1'b1;
            bus.m_tdata  <= head_next[int'(lane_next)*16 +: 16];
            bus.m_tlast  <= (lane_next == LAST_LANE);
          end else begin
            state        <= IDLE;
            bus.m_tvalid <= 1'b0;
            bus.m_tdata  <= '0;
            bus.m_tlast  <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          bus.m_tvalid <= 1'b0;
          bus.m_tdata  <= '0;
          bus.m_tlast  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vfu_out_serializer.sv
// tb_vfu_out_serializer
//   Directed bench for vfu_out_serializer. Stimulus pushes the expected
//   {last, lane} beats of every vector it expects to emerge into exp_q; a
//   negedge monitor checks each presented beat against the queue head and
//   pops it when the beat is accepted.
module tb_vfu_out_serializer;
  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int LVW   = $clog2(DEPTH) + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [LVW-1:0] level;
  logic           overflow;

  vfu_out_serializer_if #(.N(N)) bus ();

  vfu_out_serializer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  logic [16:0] exp_q[$];
  int          vec_count = 0;
  int          err_count = 0;

  localparam logic [63:0] VA = 64'h4000_3E00_3C00_3800;
  logic [63:0] vset [6];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one in_tvalid pulse; returns 1 time unit after the push edge.
  task automatic applyStimulus(input logic [63:0] vec, input bit expect_out);
    bus.vect_in_flat = vec;
    bus.in_tvalid    = 1'b1;
    if (expect_out) begin
      for (int i = 0; i < N; i++) begin
        exp_q.push_back({(i == N - 1), vec[i*16 +: 16]});
      end
    end
    @(posedge clk);
    #1;
    bus.in_tvalid = 1'b0;
  endtask

  task automatic doReset();
    rst           = 1'b0;
    bus.in_tvalid = 1'b0;
    bus.m_tready  = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(name, exp_q.size(), 0);
  endtask

  // Every presented beat must equal the queue head, also while stalled.
  always @(negedge clk) begin
    if (rst && bus.m_tvalid) begin
      if (exp_q.size() == 0) begin
        vec_count++;
        err_count++;
        $display("[TB] FAIL unexpected_beat actual=%0h expected=none at %0t",
                 {bus.m_tlast, bus.m_tdata}, $time);
      end else begin
        checkOutput("beat", {bus.m_tlast, bus.m_tdata}, exp_q[0]);
        if (bus.m_tready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vset[0] = 64'h1003_1002_1001_1000;
    vset[1] = 64'h2003_2002_2001_2000;
    vset[2] = 64'h3003_3002_3001_3000;
    vset[3] = 64'h4403_4402_4401_4400;
    vset[4] = 64'h5003_5002_5001_5000;
    vset[5] = 64'h6003_6002_6001_6000;
    bus.vect_in_flat = '0;
    bus.in_tvalid    = 1'b0;
    bus.m_tready     = 1'b0;

    // Reset state
    doReset();
    checkOutput("rst_tvalid", bus.m_tvalid, 0);
    checkOutput("rst_tdata", bus.m_tdata, 0);
    checkOutput("rst_tlast", bus.m_tlast, 0);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_overflow", overflow, 0);

    // Single vector, ready held high
    $display("[TB] single vector");
    bus.m_tready = 1'b1;
    applyStimulus(VA, 1'b1);
    checkOutput("single_tvalid_rise", bus.m_tvalid, 1);
    checkOutput("single_level1", level, 1);
    checkOutput("single_first_lane", bus.m_tdata, 16'h3800);
    waitDrain("single_drain");
    checkOutput("single_level0", level, 0);
    checkOutput("single_idle", bus.m_tvalid, 0);

    // Backpressure pattern
    $display("[TB] backpressure");
    bus.m_tready = 1'b0;
    applyStimulus(VA, 1'b1);
    for (int i = 0; i < 7; i++) begin
      bus.m_tready = pat[i];
      @(posedge clk);
      #1;
    end
    checkOutput("bp_beats_left", exp_q.size(), 0);
    checkOutput("bp_idle", bus.m_tvalid, 0);
    checkOutput("bp_level", level, 0);

    // Fill to DEPTH, fifth vector dropped
    $display("[TB] fill and overflow");
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vset[i], i < 4);
      checkOutput("fill_level", level, (i < 4) ? i + 1 : 4);
    end
    checkOutput("fill_overflow", overflow, 1);
    bus.m_tready = 1'b1;
    waitDrain("fill_drain");
    checkOutput("fill_level_end", level, 0);
    checkOutput("fill_overflow_sticky", overflow, 1);

    // Push on the same edge the head vector's last lane transfers
    $display("[TB] push and pop at full");
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(vset[i], 1'b1);
    checkOutput("pp_full_level", level, 4);
    bus.m_tready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("pp_at_lane3", bus.m_tlast, 1);
    applyStimulus(vset[5], 1'b1);
    checkOutput("pp_level", level, 4);
    checkOutput("pp_overflow", overflow, 0);
    waitDrain("pp_drain");
    checkOutput("pp_overflow_end", overflow, 0);

    // Back-to-back vectors, no bubble
    $display("[TB] back to back");
    doReset();
    bus.m_tready = 1'b1;
    applyStimulus(vset[0], 1'b1);
    applyStimulus(vset[1], 1'b1);
    applyStimulus(vset[2], 1'b1);
    checkOutput("b2b_tvalid", bus.m_tvalid, 1);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      checkOutput("b2b_tvalid", bus.m_tvalid, 1);
    end
    waitDrain("b2b_drain");
    checkOutput("b2b_overflow", overflow, 0);
    checkOutput("b2b_idle", bus.m_tvalid, 0);

    // Asynchronous reset mid-vector with a full FIFO and overflow set
    $display("[TB] async reset mid-vector");
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(vset[i], i < 4);
    checkOutput("ar_overflow_pre", overflow, 1);
    bus.m_tready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #1;
    rst = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("ar_tvalid", bus.m_tvalid, 0);
    checkOutput("ar_level", level, 0);
    checkOutput("ar_overflow", overflow, 0);
    checkOutput("ar_tdata", bus.m_tdata, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    checkOutput("ar_no_residual", bus.m_tvalid, 0);
    checkOutput("ar_level_after", level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
